// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: word sizes, format codes,
// immediate field widths and the opcodes the encoder is normally fed.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package instr_encoder_pkg;

    localparam int WORD_W  = `WORD;
    localparam int INSTR_W = `INSTR_LEN;

    typedef enum logic [1:0] {
        FMT_R  = 2'b00,
        FMT_D  = 2'b01,
        FMT_CB = 2'b10,
        FMT_B  = 2'b11
    } fmt_e;

    localparam int D_IMM_W  = 9;
    localparam int CB_IMM_W = 19;
    localparam int B_IMM_W  = 26;

    // Opcodes are left-aligned in 11 bits; CB keeps [10:3], B keeps [10:5].
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_CBZ  = 11'h5A0;
    localparam logic [10:0] OP_B    = 11'h0A0;
    localparam logic [10:0] OP_ADD  = 11'h458;

endpackage

// File: rtl/instr_encoder_imm_range_check.sv
// Truncates the 64-bit signed immediate to the field width of the format and
// flags values that do not survive the truncation.
module imm_range_check
    import instr_encoder_pkg::*;
(
    input  logic [WORD_W-1:0]  imm,
    input  fmt_e               fmt,
    output logic [B_IMM_W-1:0] field,
    output logic               err
);

    // The immediate fits when every bit from the field's sign bit upward agrees.
    logic [WORD_W-D_IMM_W:0]  d_top;
    logic [WORD_W-CB_IMM_W:0] cb_top;
    logic [WORD_W-B_IMM_W:0]  b_top;

    assign d_top  = imm[WORD_W-1:D_IMM_W-1];
    assign cb_top = imm[WORD_W-1:CB_IMM_W-1];
    assign b_top  = imm[WORD_W-1:B_IMM_W-1];

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        field = '0;
        err   = 1'b0;
        case (fmt)
            FMT_D: begin
                field = B_IMM_W'(imm[D_IMM_W-1:0]);
                err   = !((&d_top) || !(|d_top));
            end
            FMT_CB: begin
                field = B_IMM_W'(imm[CB_IMM_W-1:0]);
                err   = !((&cb_top) || !(|cb_top));
            end
            FMT_B: begin
                field = imm[B_IMM_W-1:0];
                err   = !((&b_top) || !(|b_top));
            end
            default: begin
                field = '0;
                err   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs an R/D/CB/B field set into a 32-bit instruction word behind a single
// valid/ready output register, tagging each word with a byte address.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_fmt,
    input  logic [10:0]        in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rn,
    input  logic [4:0]         in_rm,
    input  logic [WORD_W-1:0]  in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_err,
    output logic [7:0]         err_count
);

    fmt_e                 fmt;
    logic [B_IMM_W-1:0]   field;
    logic                 imm_err;
    logic [INSTR_W-1:0]   instr_next;
    logic [ADDR_W-1:0]    addr_cnt;
    logic                 accept;
    logic                 drain;

    assign fmt = fmt_e'(in_fmt);

    imm_range_check u_imm_range_check (
        .imm   (in_imm),
        .fmt   (fmt),
        .field (field),
        .err   (imm_err)
    );

    always_comb begin
        instr_next = '0;
        case (fmt)
            FMT_R:   instr_next = {in_opcode, in_rm, 6'b000000, in_rn, in_rd};
            FMT_D:   instr_next = {in_opcode, field[D_IMM_W-1:0], 2'b00, in_rn, in_rd};
            FMT_CB:  instr_next = {in_opcode[10:3], field[CB_IMM_W-1:0], in_rd};
            FMT_B:   instr_next = {in_opcode[10:5], field};
            default: instr_next = '0;
        endcase
    end

    // A single output stage: a slot frees up in the same cycle it drains.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= instr_next;
            out_addr  <= addr_cnt;
            out_err   <= imm_err;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
        end else if (clear) begin
            addr_cnt <= '0;
        end else if (accept) begin
            addr_cnt <= addr_cnt + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (drain && out_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
